// File: rtl/short_preamble_gen.sv
// Streams NUM_REP x 16-sample 802.11 short training field from the STF ROM; edge window optional via PREAMBLE_WINDOW_EN.
// Latency: first sample valid the cycle after an accepted start, then one sample per handshake.
// Backpressure: out_ready low freezes the output sample, out_last and idx; no drop or duplicate.
module short_preamble_gen #(
    parameter int NUM_REP  = 10,
    parameter int IDX_W    = 8,
    parameter int SAMPLE_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic [3:0]          rom_addr,
    input  logic [SAMPLE_W-1:0] rom_i,
    input  logic [SAMPLE_W-1:0] rom_q,
    output logic [SAMPLE_W-1:0] out_i,
    output logic [SAMPLE_W-1:0] out_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(16 * NUM_REP - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [SAMPLE_W-1:0] ld_i;
    logic [SAMPLE_W-1:0] ld_q;

    assign rom_addr = idx[3:0];

`ifdef PREAMBLE_WINDOW_EN
    // Index 0 is loaded from IDLE; the final index is loaded when idx reaches it in RUN.
    logic edge_smp;
    assign edge_smp = (state == IDLE) || (idx == LAST_IDX);

    always_comb begin
        ld_i = rom_i;
        ld_q = rom_q;
        if (edge_smp) begin
            ld_i = {rom_i[SAMPLE_W-1], rom_i[SAMPLE_W-1:1]};
            ld_q = {rom_q[SAMPLE_W-1], rom_q[SAMPLE_W-1:1]};
        end
    end
`else
    assign ld_i = rom_i;
    assign ld_q = rom_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // done still high means the burst just ended: a start here is dropped.
                    if (start && !done) begin
                        out_i     <= ld_i;
                        out_q     <= ld_q;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                        idx       <= IDX_W'(1);
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            idx       <= '0;
                            state     <= IDLE;
                        end else begin
                            out_i    <= ld_i;
                            out_q    <= ld_q;
                            out_last <= (idx == LAST_IDX);
                            idx      <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_short_preamble_gen.sv
// Randomized and directed bench for short_preamble_gen against a sample-index reference model.
module tb_short_preamble_gen;

    localparam int NR = 10;
    localparam int N  = 16 * NR;
    localparam int W  = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   rom_addr;
    logic [W-1:0] rom_i, rom_q, out_i, out_q;
    logic         out_valid, out_last, busy, done;

    logic [15:0] rom_i_t [16] = '{16'h05E3, 16'hEF0C, 16'hFE56, 16'h124E, 16'h0BC7, 16'h124E, 16'hFE56, 16'hEF0C,
                                  16'h05E3, 16'h004D, 16'hF5E3, 16'hFE56, 16'h0000, 16'hFE56, 16'hF5E3, 16'h004D};
    logic [15:0] rom_q_t [16] = '{16'h05E3, 16'h004D, 16'hF5E3, 16'hFE56, 16'h0000, 16'hFE56, 16'hF5E3, 16'h004D,
                                  16'h05E3, 16'hEF0C, 16'hFE56, 16'h124E, 16'h0BC7, 16'h124E, 16'hFE56, 16'hEF0C};

    assign rom_i = rom_i_t[rom_addr];
    assign rom_q = rom_q_t[rom_addr];

    short_preamble_gen #(.NUM_REP(NR), .IDX_W(8), .SAMPLE_W(W)) dut (
        .clock(clock), .reset(reset), .start(start), .rom_addr(rom_addr),
        .rom_i(rom_i), .rom_q(rom_q), .out_i(out_i), .out_q(out_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] exp_s(input int k, input bit q);
        logic [15:0] s;
        s = q ? rom_q_t[k % 16] : rom_i_t[k % 16];
`ifdef PREAMBLE_WINDOW_EN
        if (k == 0 || k == N - 1) s = 16'($signed(s) >>> 1);
`endif
        return s;
    endfunction

    // Reference model: burst state is just "active" plus the index of the sample on the bus.
    bit          m_active   = 0;
    int          m_k        = 0;
    bit          m_pend_done = 0;
    int          bursts     = 0;
    logic [15:0] cap_i[$];
    logic [15:0] cap_q[$];

    always @(negedge clock) begin
        bit nd;
        if (reset) begin
            m_active    = 0;
            m_k         = 0;
            m_pend_done = 0;
        end else begin
            chk("out_valid", out_valid, m_active);
            chk("busy", busy, m_active);
            chk("done", done, m_pend_done);
            chk("last_and_done", out_last & done, 1'b0);
            if (m_active) begin
                chk("out_i", out_i, exp_s(m_k, 0));
                chk("out_q", out_q, exp_s(m_k, 1));
                chk("out_last", out_last, m_k == N - 1);
            end else begin
                chk("rom_addr_idle", rom_addr, 4'd0);
            end
            nd = 0;
            if (m_active && out_ready) begin
                cap_i.push_back(out_i);
                cap_q.push_back(out_q);
                m_k++;
                if (m_k == N) begin
                    m_active = 0;
                    m_k      = 0;
                    nd       = 1;
                    bursts++;
                end
            end else if (!m_active && start && !m_pend_done) begin
                m_active = 1;
                m_k      = 0;
            end
            m_pend_done = nd;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_cap();
        cap_i.delete();
        cap_q.delete();
    endtask

    task automatic wait_burst(input int b0, input int budget, output int c);
        for (c = 0; c < budget && bursts == b0; c++) tick();
        chk("burst_timeout", bursts != b0, 1'b1);
    endtask

    task automatic chk_capture(input string nm);
        chk({nm, "_len"}, cap_i.size(), N);
        if (cap_i.size() == N) begin
            for (int k = 0; k < N; k++) begin
                if (cap_i[k] !== exp_s(k, 0) || cap_q[k] !== exp_s(k, 1))
                    chk({nm, "_seq"}, {cap_i[k], cap_q[k]}, {exp_s(k, 0), exp_s(k, 1)});
            end
            chk({nm, "_seq_ok"}, 1'b1, 1'b1 & (cap_i.size() == N));
        end
    endtask

    initial begin
        int c, b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        #4;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_out_i", out_i, 16'h0000);
        chk("reset_addr", rom_addr, 4'd0);

        // Full burst with ready held high: 160 consecutive samples.
        tick();
        out_ready = 1'b1;
        clear_cap();
        b0 = bursts;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_burst(b0, 400, c);
        chk("burst_cycles", c, 160);
        chk_capture("burst1");
        if (cap_i.size() == N) begin
`ifdef PREAMBLE_WINDOW_EN
            chk("first_sample", {cap_i[0], cap_q[0]}, 32'h02F1_02F1);
            chk("last_sample", {cap_i[N-1], cap_q[N-1]}, 32'h0026_F786);
`else
            chk("first_sample", {cap_i[0], cap_q[0]}, 32'h05E3_05E3);
            chk("last_sample", {cap_i[N-1], cap_q[N-1]}, 32'h004D_EF0C);
`endif
            chk("sample1", {cap_i[1], cap_q[1]}, 32'hEF0C_004D);
            chk("sample15", {cap_i[15], cap_q[15]}, 32'h004D_EF0C);
            chk("sample16", {cap_i[16], cap_q[16]}, 32'h05E3_05E3);
            for (int k = 16; k < N - 1; k++)
                if (cap_i[k] !== cap_i[k % 16] || cap_q[k] !== cap_q[k % 16])
                    chk("rep_identical", {cap_i[k], cap_q[k]}, {cap_i[k % 16], cap_q[k % 16]});
        end
        repeat (3) tick();

        // Random backpressure burst.
        clear_cap();
        b0 = bursts;
        start = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        for (c = 0; c < 3000 && bursts == b0; c++) begin
            out_ready = ($urandom_range(0, 99) < 55);
            tick();
        end
        chk("bp_timeout", bursts != b0, 1'b1);
        chk_capture("bp");
        out_ready = 1'b1;
        repeat (3) tick();

        // Starts at sample 50 and coincident with done are ignored.
        clear_cap();
        b0 = bursts;
        start = 1'b1;
        tick();
        for (int cyc = 1; cyc < 200; cyc++) begin
            start = (cyc == 51 || cyc == 161);
            tick();
        end
        start = 1'b0;
        chk("ignore_start_bursts", bursts, b0 + 1);
        chk_capture("ignore_start");
        chk("ignore_start_idle", out_valid, 1'b0);

        // Reset in the middle of a burst aborts it.
        clear_cap();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 81; cyc++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #4;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_addr", rom_addr, 4'd0);
        tick();
        clear_cap();
        b0 = bursts;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_burst(b0, 400, c);
        chk_capture("after_abort");
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
